// File: rtl/i2s_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_adc_capture
//  Purpose  : Oversampled I2S ADC receiver. Converts the codec serial stream
//             (BCLK / ADCLRCK / ADCDAT) into {left, right} frames and buffers
//             them in a small FIFO behind a valid/ready stream interface.
//  Options  : LEFT_JUSTIFIED_MODE_EN - when defined, the MSB is taken on the
//             first BCLK rise after the LRCK edge (left-justified format);
//             otherwise the standard I2S one-bit delay is honoured.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_adc_capture #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        audio_BCLK,
    input  logic                        audio_ADCLRCK,
    input  logic                        audio_ADCDAT,
    input  logic                        enable,
    input  logic                        clear_ovf,
    output logic [2*SAMPLE_W-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(SAMPLE_W + 1);
    localparam int c_FRM_W = 2 * SAMPLE_W;
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SAMPLE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_SHIFT = 2'd2,
        S_PAD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic bclk_s1_q, bclk_s2_q, bclk_h_q;
    logic lrck_s1_q, lrck_s2_q, lrck_prev_q;
    logic dat_s1_q,  dat_s2_q;

    // Bring the asynchronous codec pins into the clk_clk domain.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_h_q  <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            dat_s1_q  <= 1'b0;
            dat_s2_q  <= 1'b0;
        end else begin
            bclk_s1_q <= audio_BCLK;
            bclk_s2_q <= bclk_s1_q;
            bclk_h_q  <= bclk_s2_q;
            lrck_s1_q <= audio_ADCLRCK;
            lrck_s2_q <= lrck_s1_q;
            dat_s1_q  <= audio_ADCDAT;
            dat_s2_q  <= dat_s1_q;
        end
    end

    logic                w_bclk_rise;
    logic                w_lrck_edge;
    logic [SAMPLE_W-1:0] w_word;
    logic [SAMPLE_W-2:0] shreg_q;

    assign w_bclk_rise = bclk_s2_q & ~bclk_h_q;
    // LRCK and data are only meaningful at BCLK rises, so the edge test
    // compares against the value captured at the previous rise.
    assign w_lrck_edge = w_bclk_rise && (lrck_s2_q != lrck_prev_q);
    assign w_word      = {shreg_q, dat_s2_q};

    // ------------------------------------------------------------------
    // Word start: in I2S mode the rise that reveals the LRCK edge carries
    // the delay bit, so the MSB arrives on the following rise (DELAY).
    // In left-justified mode that same rise already carries the MSB.
    // ------------------------------------------------------------------
    state_t              w_start_state;
    logic [SAMPLE_W-2:0] w_start_shreg;
    logic [c_CNT_W-1:0]  w_start_cnt;

`ifdef LEFT_JUSTIFIED_MODE_EN
    assign w_start_state = S_SHIFT;
    assign w_start_shreg = {{(SAMPLE_W-2){1'b0}}, dat_s2_q};
    assign w_start_cnt   = c_CNT_W'(1);
`else
    assign w_start_state = S_DELAY;
    assign w_start_shreg = '0;
    assign w_start_cnt   = '0;
`endif

    // ------------------------------------------------------------------
    // Deserialiser FSM
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 ch_q;          // 0 = left word, 1 = right word
    logic                 left_valid_q;
    logic [SAMPLE_W-1:0]  left_q;
    logic [c_FRM_W-1:0]   frame_q;
    logic                 push_q;

    // Track LRCK, shift bits in and assemble {left, right} frames.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ch_q         <= 1'b0;
            shreg_q      <= '0;
            left_valid_q <= 1'b0;
            left_q       <= '0;
            frame_q      <= '0;
            push_q       <= 1'b0;
            lrck_prev_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (w_bclk_rise) begin
                lrck_prev_q <= lrck_s2_q;
            end
            if (!enable) begin
                state_q      <= S_IDLE;
                cnt_q        <= '0;
                shreg_q      <= '0;
                left_valid_q <= 1'b0;
                left_q       <= '0;
            end else if (w_bclk_rise) begin
                case (state_q)
                    S_IDLE: begin
                        if (w_lrck_edge && !lrck_s2_q) begin
                            state_q      <= w_start_state;
                            shreg_q      <= w_start_shreg;
                            cnt_q        <= w_start_cnt;
                            ch_q         <= 1'b0;
                            left_valid_q <= 1'b0;
                        end
                    end
                    S_DELAY, S_SHIFT: begin
                        if (w_lrck_edge) begin
                            // Short word: drop it together with any held left.
                            left_valid_q <= 1'b0;
                            left_q       <= '0;
                            if (!lrck_s2_q) begin
                                state_q <= w_start_state;
                                shreg_q <= w_start_shreg;
                                cnt_q   <= w_start_cnt;
                                ch_q    <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                shreg_q <= '0;
                                cnt_q   <= '0;
                            end
                        end else begin
                            shreg_q <= w_word[SAMPLE_W-2:0];
                            cnt_q   <= cnt_q + c_CNT_W'(1);
                            state_q <= S_SHIFT;
                            if (cnt_q == c_LAST) begin
                                state_q <= S_PAD;
                                if (!ch_q) begin
                                    left_q       <= w_word;
                                    left_valid_q <= 1'b1;
                                end else begin
                                    frame_q      <= {left_q, w_word};
                                    push_q       <= 1'b1;
                                    left_valid_q <= 1'b0;
                                end
                            end
                        end
                    end
                    S_PAD: begin
                        if (w_lrck_edge) begin
                            if (!lrck_s2_q) begin
                                state_q      <= w_start_state;
                                shreg_q      <= w_start_shreg;
                                cnt_q        <= w_start_cnt;
                                ch_q         <= 1'b0;
                                left_valid_q <= 1'b0;
                            end else if (left_valid_q) begin
                                state_q <= w_start_state;
                                shreg_q <= w_start_shreg;
                                cnt_q   <= w_start_cnt;
                                ch_q    <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO (first-word-fall-through, registered head)
    // ------------------------------------------------------------------
    logic [c_FRM_W-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]   count_q, count_d, w_remain;
    logic [c_FRM_W-1:0] out_data_q, out_data_d;
    logic               out_valid_q, overflow_q;
    logic               w_rd, w_wr, w_drop;

    // A read at full frees the slot for a coincident write.
    assign w_rd     = out_valid_q && out_ready;
    assign w_wr     = push_q && ((count_q != c_DEPTH) || w_rd);
    assign w_drop   = push_q && !w_wr;
    assign count_d  = count_q + (c_PTR_W + 1)'(w_wr) - (c_PTR_W + 1)'(w_rd);
    assign rd_ptr_d = rd_ptr_q + c_PTR_W'(w_rd);
    assign w_remain = count_q - (c_PTR_W + 1)'(w_rd);

    // Next head word: bypass the incoming frame when nothing older remains.
    always_comb begin
        out_data_d = out_data_q;
        if (w_remain != '0) begin
            out_data_d = mem_q[rd_ptr_d];
        end else if (w_wr) begin
            out_data_d = frame_q;
        end
    end

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk_clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= frame_q;
        end
    end

    // Pointers, fill count, registered head and sticky overflow.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= (count_d != '0);
            overflow_q  <= (overflow_q && !clear_ovf) || w_drop;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;
    assign fill_level = count_q;

endmodule
`default_nettype wire
